// File: rtl/controlador_atributos_n.sv
// controlador_atributos_n
// N saturating attribute counters updated once per prescaled tick, with
// per-channel low-level alarms (hysteresis) and a sticky death flag raised
// when any attribute has been held at zero for ZERO_TICKS applied updates.

module controlador_atributos_n #(
    parameter int                          N_ATTR       = 3,
    parameter int                          WIDTH        = 8,
    parameter int                          MAX_VAL      = 100,
    parameter logic [N_ATTR*WIDTH-1:0]     INICIAL      = {8'd50, 8'd70, 8'd80},
    parameter int                          TICK_DIV     = 2**26,
    parameter int                          VEL_DESCIDA  = 1,
    parameter int                          VEL_SUBIDA   = 7,
    parameter int                          LIMIAR_BAIXO = 20,
    parameter int                          LIMIAR_SAIDA = 30,
    parameter int                          ZERO_TICKS   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_ATTR-1:0]        sobe,
    input  logic                     congela,
    output logic [N_ATTR*WIDTH-1:0]  atributos,
    output logic [N_ATTR-1:0]        alerta,
    output logic                     morte,
    output logic                     tick
);

    // Prescaler and zero-counter widths; arithmetic on attributes uses one
    // extra bit so that neither the rise nor the fall can wrap around.
    localparam int              CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int              ZW      = $clog2(ZERO_TICKS + 1);
    localparam logic [CW-1:0]   ULTIMO  = CW'(TICK_DIV - 1);
    localparam logic [ZW-1:0]   ZMAX    = ZW'(ZERO_TICKS);
    localparam logic [WIDTH:0]  MAXV    = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]  SUBIDA  = (WIDTH+1)'(VEL_SUBIDA);
    localparam logic [WIDTH:0]  DESCIDA = (WIDTH+1)'(VEL_DESCIDA);
    localparam logic [WIDTH:0]  BAIXO   = (WIDTH+1)'(LIMIAR_BAIXO);
    localparam logic [WIDTH:0]  SAIDA   = (WIDTH+1)'(LIMIAR_SAIDA);

    logic [CW-1:0]              contador;
    logic [ZW-1:0]              zcnt      [N_ATTR];
    logic [ZW-1:0]              zcnt_prox [N_ATTR];
    logic [N_ATTR*WIDTH-1:0]    atrib_prox;
    logic [N_ATTR-1:0]          alerta_prox;
    logic                       morre;
    logic                       tick_evt;
    logic                       aplica;
    logic [WIDTH:0]             v;
    logic [WIDTH:0]             nv;

    // Tick edge and whether this tick actually changes the attributes.
    always_comb begin
        tick_evt = (contador == ULTIMO);
        aplica   = tick_evt && !congela && !morte;
    end

    // Next attribute, alarm and zero-counter values for an applied update;
    // everything holds when no update is applied.
    always_comb begin
        atrib_prox  = atributos;
        alerta_prox = alerta;
        morre       = 1'b0;
        v           = '0;
        nv          = '0;
        for (int i = 0; i < N_ATTR; i++) begin
            zcnt_prox[i] = zcnt[i];
        end
        if (aplica) begin
            for (int i = 0; i < N_ATTR; i++) begin
                v = {1'b0, atributos[i*WIDTH +: WIDTH]};
                if (sobe[i]) begin
                    nv = v + SUBIDA;
                    if (nv > MAXV) begin
                        nv = MAXV;
                    end
                end else if (v >= DESCIDA) begin
                    nv = v - DESCIDA;
                end else begin
                    nv = '0;
                end
                atrib_prox[i*WIDTH +: WIDTH] = nv[WIDTH-1:0];

                if (nv <= BAIXO) begin
                    alerta_prox[i] = 1'b1;
                end else if (nv >= SAIDA) begin
                    alerta_prox[i] = 1'b0;
                end

                if (nv == '0) begin
                    if (zcnt[i] != ZMAX) begin
                        zcnt_prox[i] = zcnt[i] + ZW'(1);
                    end
                end else begin
                    zcnt_prox[i] = '0;
                end

                if (zcnt_prox[i] == ZMAX) begin
                    morre = 1'b1;
                end
            end
        end
    end

    // State registers: the prescaler free-runs, attributes and alarms move
    // only on applied updates, and the death flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            contador  <= '0;
            tick      <= 1'b0;
            atributos <= INICIAL;
            alerta    <= '0;
            morte     <= 1'b0;
            for (int i = 0; i < N_ATTR; i++) begin
                zcnt[i] <= '0;
            end
        end else begin
            contador  <= tick_evt ? '0 : contador + CW'(1);
            tick      <= tick_evt;
            atributos <= atrib_prox;
            alerta    <= alerta_prox;
            morte     <= morte || morre;
            for (int i = 0; i < N_ATTR; i++) begin
                zcnt[i] <= zcnt_prox[i];
            end
        end
    end

endmodule

// File: doc/controlador_atributos_n.md
# controlador_atributos_n

Parametrised successor to the pet attribute controller. Holds N saturating attribute counters (hunger, happiness, sleep by default), updates them once per prescaled tick, raises per-attribute low-level alarms with hysteresis, and latches a death flag when any attribute stays at zero for a configurable number of ticks. It sits between the game state machine and the display/status logic. Each tick, the state machine tells it which attributes rise and whether updates are frozen.

## Interface
- N_ATTR, 3: number of attribute channels.
- WIDTH, 8: bits per attribute.
- MAX_VAL, 100: saturation ceiling. Constraint: MAX_VAL < 2^WIDTH.
- INICIAL, {8'd50, 8'd70, 8'd80}: reset value per channel, packed. Channel 0 is the LSB slice (0 = fome 80, 1 = felicidade 70, 2 = sono 50). Each value must be ≤ MAX_VAL.
- TICK_DIV, 2^26: clock cycles per tick. Must be ≥ 2.
- VEL_DESCIDA, 1: decrement per tick.
- VEL_SUBIDA, 7: increment per tick.
- LIMIAR_BAIXO, 20: alarm set threshold.
- LIMIAR_SAIDA, 30: alarm clear threshold. Constraint: LIMIAR_BAIXO < LIMIAR_SAIDA ≤ MAX_VAL.
- ZERO_TICKS, 3: consecutive applied updates at zero that trigger death. Must be ≥ 1.

Ports:
- clk, in, 1: single system clock.
- rst, in, 1: synchronous, active-high reset. Has priority over all other inputs.
- sobe, in, N_ATTR: bit i = 1 makes channel i rise on the next tick; 0 makes it fall.
- congela, in, 1: 1 suppresses attribute updates (used for INTRO screens and pause).
- atributos, out, N_ATTR*WIDTH: packed registered attribute values.
- alerta, out, N_ATTR: registered low-level alarm per channel.
- morte, out, 1: sticky death flag.
- tick, out, 1: one-cycle pulse marking an update edge.

## Operation
Prescaler:
- `contador` runs 0..TICK_DIV-1 and wraps to 0.
- It runs continuously regardless of congela or morte.
- The tick event is the clock edge at which contador == TICK_DIV-1.

Applied update: a tick event with congela = 0 and morte = 0. For each channel i:
- If sobe[i] = 1: v ← min(v + VEL_SUBIDA, MAX_VAL).
- If sobe[i] = 0: v ← max(v − VEL_DESCIDA, 0).
- Arithmetic is done in WIDTH+1 bits. No wrap-around is permitted in either direction.

Zero counter (per channel, `zcnt[i]`):
- On an applied update, if the new v == 0, zcnt[i] increments, saturating at ZERO_TICKS.
- On an applied update with new v ≠ 0, zcnt[i] is cleared.
- Without an applied update, zcnt[i] holds.

Death:
- morte ← 1 on the same edge at which any zcnt reaches ZERO_TICKS.
- It stays 1 until rst.
- While morte = 1, atributos, alerta and zcnt freeze. The tick output keeps pulsing.

Alarm, evaluated on applied updates using the new v:
- Set if v ≤ LIMIAR_BAIXO.
- Clear if v ≥ LIMIAR_SAIDA.
- Otherwise hold.

Freeze:
- While congela = 1, attributes, alarms and zero counters hold.
- A tick event occurring while congela = 1 is lost; it is not deferred.

Reset values:
- atributos = INICIAL
- alerta = 0
- morte = 0
- tick = 0
- contador = 0
- zcnt = 0

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- The first tick edge is the TICK_DIV-th rising edge after the edge that samples rst = 0 with contador = 0. Consecutive ticks are exactly TICK_DIV cycles apart.
- At a tick edge, tick goes to 1 for exactly one cycle. During that cycle the new atributos, alerta and morte are already visible.
- sobe and congela are sampled only at the tick edge. Values in other cycles are don't-care.
- Simultaneous events on one tick:
  - Several channels may hit zero on the same tick; a single morte assertion covers them.
  - A channel that reaches ZERO_TICKS on the same edge as an update is frozen at the updated value.
- rst mid-operation: the next edge restores all reset values, and the prescaler restarts from 0.

## Test plan
- Reset/first tick (TICK_DIV=4, default INICIAL, sobe=000, congela=0): release rst → tick pulses on the 4th edge; atributos = {49, 69, 79}; next tick exactly 4 cycles later gives {48, 68, 78}.
- Rise saturation: channel 0 preloaded at 95 via INICIAL, sobe[0]=1 → after tick 1, channel 0 = 100; after tick 2, still 100. Channel 1 at 0 with sobe[1]=0 stays 0 (no underflow to 255).
- Hysteresis: channel falling from 22 → alerta[0] = 1 at value 20. Then with sobe[0]=1, it rises 27 (alerta still 1), 34 (alerta clears to 0).
- Death (ZERO_TICKS=3): channel 2 at 1, falling → reaches 0 on tick 1; morte = 1 exactly at tick 3. Further ticks change no attribute. morte stays 1 until rst, and rst restores INICIAL.
- Freeze: congela = 1 across two ticks → atributos and zcnt unchanged while tick still pulses. Dropping congela resumes updates at the next tick only.
- Mid-count reset: assert rst when contador = 2 → next edge shows all reset values; the next tick occurs 4 edges after rst deasserts.
